sample_tick_gen: RTL and testbench

Multi-channel, parametrised sample-rate tick generator for the SPI/DSP front end. Each channel holds a programmable period and mode (periodic or one-shot), counts enabled clock cycles, and emits a single-cycle tick at every terminal count. Period and enable are written through val/rdy ports; a global sync realigns all channels. It replaces the single-channel, level-flag counter, so downstream samplers get clean one-cycle strobes at independent rates.

---
 rtl/sample_tick_gen_pkg.sv | 36 +++
 rtl/sample_tick_gen_tick_channel.sv | 108 ++++++++++
 rtl/sample_tick_gen.sv | 93 +++++++++
 tb/tb_sample_tick_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// sample_tick_pkg
// Shared types and width helpers for the sample-rate tick generator.
//   mode_t     : per-channel counting mode (periodic / one-shot)
//   state_t    : per-channel FSM state (IDLE / RUN / DONE)
//   chan_width : width of the channel-select field for a given channel count
//   cfg_width  : total width of the {chan, mode, period} config message
// -----------------------------------------------------------------------------
package sample_tick_pkg;

   typedef enum logic {
      PERIODIC = 1'b0,
      ONESHOT  = 1'b1
   } mode_t;

   // Fixed encodings so the state register reads the same in any tool.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // A single channel still needs a one-bit select field.
   function automatic int chan_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cfg_width(input int n, input int w);
      return chan_width(n) + 1 + w;
   endfunction

endpackage

// File: rtl/sample_tick_gen_tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One programmable tick counter. Counts down from period-1 while in RUN and
// emits a registered single-cycle tick on the cycle after count==0 is seen.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : config write targeted at this channel this cycle
//   period     : period carried by the config write
//   mode       : mode carried by the config write (0 periodic, 1 one-shot)
//   en         : enable bit as currently registered
//   en_next    : enable bit after this edge (differs from en on a mask write)
//   sync       : global phase restart
//   tick       : single-cycle tick
//   busy       : channel is in RUN
// Event priority per edge: reset > load > sync > enable change > counting.
// Any event other than plain counting leaves tick low for that edge.
// -----------------------------------------------------------------------------
module tick_channel
   import sample_tick_pkg::*;
#(
   parameter int nbits = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [nbits-1:0] period,
   input  logic             mode,
   input  logic             en,
   input  logic             en_next,
   input  logic             sync,
   output logic             tick,
   output logic             busy
);

   localparam logic [nbits-1:0] one_c = nbits'(1);

   logic [nbits-1:0] period_q, period_d;
   mode_t            mode_q, mode_d;
   state_t           state_q, state_d;
   logic [nbits-1:0] count_q, count_d;
   logic             tick_q, tick_d;

   always_comb begin
      period_d = period_q;
      mode_d   = mode_q;
      state_d  = state_q;
      count_d  = count_q;
      tick_d   = 1'b0;

      if (load) begin
         period_d = period;
         mode_d   = mode_t'(mode);
         // Period 0 disables the channel; P-1 is never formed for it.
         if (period != '0) begin
            count_d = period - one_c;
            state_d = en_next ? RUN : IDLE;
         end else begin
            count_d = '0;
            state_d = IDLE;
         end
      end else if (sync && (period_q != '0) && en_next) begin
         count_d = period_q - one_c;
         state_d = RUN;
      end else if (en_next && !en) begin
         // Resume from the held count; DONE is left only by load or sync.
         if ((period_q != '0) && (state_q == IDLE)) begin
            state_d = RUN;
         end
      end else if (!en_next && en) begin
         // Pause: count is held so the phase picks up where it stopped.
         if (state_q == RUN) begin
            state_d = IDLE;
         end
      end else if (state_q == RUN) begin
         if (count_q == '0) begin
            tick_d = 1'b1;
            // RUN is only reachable with a non-zero period.
            if (mode_q == ONESHOT) begin
               state_d = DONE;
            end else begin
               count_d = period_q - one_c;
            end
         end else begin
            count_d = count_q - one_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period_q <= '0;
         mode_q   <= PERIODIC;
         state_q  <= IDLE;
         count_q  <= '0;
         tick_q   <= 1'b0;
      end else begin
         period_q <= period_d;
         mode_q   <= mode_d;
         state_q  <= state_d;
         count_q  <= count_d;
         tick_q   <= tick_d;
      end
   end

   assign tick = tick_q;
   assign busy = (state_q == RUN);

endmodule

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Multi-channel sample-rate tick generator. Decodes config writes to one
// channel, registers the shared enable mask and fans out the global sync.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cfg_msg         : {chan, mode, period}
//   cfg_val/cfg_rdy : config write handshake
//   en_msg          : per-channel enable mask
//   en_val/en_rdy   : enable-mask write handshake
//   sync_val        : restart phase of all enabled, configured channels
//   tick            : per-channel single-cycle tick
//   busy            : per-channel RUN indication
// Handshake: a write is taken on the rising edge where val && rdy; rdy is low
// only while reset is asserted, so there is no back-pressure otherwise.
// -----------------------------------------------------------------------------
module sample_tick_gen
   import sample_tick_pkg::*;
#(
   parameter int nbits = 32,
   parameter int nch   = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [cfg_width(nch, nbits)-1:0]   cfg_msg,
   input  logic                               cfg_val,
   output logic                               cfg_rdy,
   input  logic [nch-1:0]                     en_msg,
   input  logic                               en_val,
   output logic                               en_rdy,
   input  logic                               sync_val,
   output logic [nch-1:0]                     tick,
   output logic [nch-1:0]                     busy
);

   localparam int cw = chan_width(nch);

   typedef struct packed {
      logic [cw-1:0]    chan;
      logic             mode;
      logic [nbits-1:0] period;
   } cfg_t;

   cfg_t           cfg;
   logic           cfg_wr;
   logic           en_wr;
   logic [nch-1:0] en_mask_q, en_mask_d;

   assign cfg     = cfg_t'(cfg_msg);
   assign cfg_rdy = !reset;
   assign en_rdy  = !reset;
   assign cfg_wr  = cfg_val && cfg_rdy;
   assign en_wr   = en_val && en_rdy;

   always_comb begin
      en_mask_d = en_mask_q;
      if (en_wr) begin
         en_mask_d = en_msg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_mask_q <= '0;
      end else begin
         en_mask_q <= en_mask_d;
      end
   end

   for (genvar c = 0; c < nch; c++) begin : g_ch
      logic load;

      // Channel numbers at or above nch match no instance, so such writes
      // are accepted and dropped.
      assign load = cfg_wr && (cfg.chan == cw'(c));

      tick_channel #(
         .nbits (nbits)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .load    (load),
         .period  (cfg.period),
         .mode    (cfg.mode),
         .en      (en_mask_q[c]),
         .en_next (en_mask_d[c]),
         .sync    (sync_val),
         .tick    (tick[c]),
         .busy    (busy[c])
      );
   end

endmodule

// File: tb/tb_sample_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_sample_tick_gen
// Directed bench for sample_tick_gen. Main instance: nbits=32, nch=4.
// Second instance: nbits=8, nch=3 for the out-of-range channel and the
// maximum-period spacing.
// Cycle numbering in comments: cycle 0 is the state right after a write edge,
// cycle k the state after the k-th following rising edge.
// -----------------------------------------------------------------------------
module tb_sample_tick_gen;

   logic        clk;
   logic        reset;

   logic [34:0] cfg_msg;
   logic        cfg_val;
   logic        cfg_rdy;
   logic [3:0]  en_msg;
   logic        en_val;
   logic        en_rdy;
   logic        sync_val;
   logic [3:0]  tick;
   logic [3:0]  busy;

   logic [10:0] cfg8_msg;
   logic        cfg8_val;
   logic        cfg8_rdy;
   logic [2:0]  en8_msg;
   logic        en8_val;
   logic        en8_rdy;
   logic        sync8_val;
   logic [2:0]  tick8;
   logic [2:0]  busy8;

   int checks;
   int failures;

   sample_tick_gen #(.nbits(32), .nch(4)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .cfg_msg  (cfg_msg),
      .cfg_val  (cfg_val),
      .cfg_rdy  (cfg_rdy),
      .en_msg   (en_msg),
      .en_val   (en_val),
      .en_rdy   (en_rdy),
      .sync_val (sync_val),
      .tick     (tick),
      .busy     (busy)
   );

   sample_tick_gen #(.nbits(8), .nch(3)) u_dut8 (
      .clk      (clk),
      .reset    (reset),
      .cfg_msg  (cfg8_msg),
      .cfg_val  (cfg8_val),
      .cfg_rdy  (cfg8_rdy),
      .en_msg   (en8_msg),
      .en_val   (en8_val),
      .en_rdy   (en8_rdy),
      .sync_val (sync8_val),
      .tick     (tick8),
      .busy     (busy8)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   task automatic tick_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic md, input logic [31:0] p);
      cfg_msg = {ch, md, p};
      cfg_val = 1'b1;
      tick_cycle();
      cfg_val = 1'b0;
   endtask

   task automatic en_write(input logic [3:0] mask);
      en_msg = mask;
      en_val = 1'b1;
      tick_cycle();
      en_val = 1'b0;
   endtask

   task automatic sync_pulse();
      sync_val = 1'b1;
      tick_cycle();
      sync_val = 1'b0;
   endtask

   // ---------------- checker ----------------
   task automatic check(input string tag, input int idx, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      cfg_msg   = '0;
      cfg_val   = 1'b0;
      en_msg    = '0;
      en_val    = 1'b0;
      sync_val  = 1'b0;
      cfg8_msg  = '0;
      cfg8_val  = 1'b0;
      en8_msg   = '0;
      en8_val   = 1'b0;
      sync8_val = 1'b0;

      // Reset held for 3 cycles.
      for (int i = 0; i < 3; i++) begin
         tick_cycle();
         check("reset_tick", i, tick, 4'b0000);
         check("reset_busy", i, busy, 4'b0000);
         check("reset_cfg_rdy", i, cfg_rdy, 1'b0);
         check("reset_en_rdy", i, en_rdy, 1'b0);
         check("reset_tick8", i, tick8, 3'b000);
         check("reset_busy8", i, busy8, 3'b000);
      end
      reset = 1'b0;
      #1;
      check("post_reset_cfg_rdy", 0, cfg_rdy, 1'b1);
      check("post_reset_en_rdy", 0, en_rdy, 1'b1);
      check("post_reset_cfg8_rdy", 0, cfg8_rdy, 1'b1);

      // Periodic: ch0 P=4, ticks at cycles 4, 8, 12.
      en_write(4'b0001);
      check("en_p0_busy", 0, busy, 4'b0000);
      cfg_write(2'd0, 1'b0, 32'd4);
      check("periodic_busy", 0, busy, 4'b0001);
      check("periodic_tick", 0, tick, 4'b0000);
      for (int i = 1; i <= 12; i++) begin
         tick_cycle();
         check("periodic_tick", i, tick, (i % 4 == 0) ? 4'b0001 : 4'b0000);
      end

      // Collision: next tick due at 16 (count==0 at 15); reconfigure on edge 16.
      for (int i = 13; i <= 15; i++) begin
         tick_cycle();
         check("pre_collision_tick", i, tick, 4'b0000);
      end
      cfg_write(2'd0, 1'b0, 32'd2);
      check("collision_suppressed", 0, tick, 4'b0000);
      for (int i = 1; i <= 4; i++) begin
         tick_cycle();
         check("collision_tick", i, tick, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      end
      en_write(4'b0000);
      check("ch0_paused_busy", 0, busy, 4'b0000);

      // One-shot: ch1 P=3, single tick at cycle 3, then not busy.
      en_write(4'b0010);
      cfg_write(2'd1, 1'b1, 32'd3);
      check("oneshot_busy", 0, busy, 4'b0010);
      for (int i = 1; i <= 8; i++) begin
         tick_cycle();
         check("oneshot_tick", i, tick, (i == 3) ? 4'b0010 : 4'b0000);
         check("oneshot_busy", i, busy, (i < 3) ? 4'b0010 : 4'b0000);
      end
      sync_pulse();
      check("oneshot_sync_busy", 0, busy, 4'b0010);
      for (int i = 1; i <= 5; i++) begin
         tick_cycle();
         check("oneshot_sync_tick", i, tick, (i == 3) ? 4'b0010 : 4'b0000);
      end

      // Pause/resume: ch2 P=5. Unpaused tick would be at 5. Disable on edge 3
      // (count 2 seen), re-enable on edge 6: frozen on 4 edges, tick moves to 9.
      en_write(4'b0100);
      check("done_ignores_en", 0, busy, 4'b0000);
      cfg_write(2'd2, 1'b0, 32'd5);
      for (int i = 1; i <= 2; i++) begin
         tick_cycle();
         check("pause_pre_tick", i, tick, 4'b0000);
      end
      en_write(4'b0000);
      check("pause_busy", 3, busy, 4'b0000);
      for (int i = 4; i <= 5; i++) begin
         tick_cycle();
         check("pause_hold_busy", i, busy, 4'b0000);
         check("pause_hold_tick", i, tick, 4'b0000);
      end
      en_write(4'b0100);
      check("resume_busy", 6, busy, 4'b0100);
      for (int i = 7; i <= 19; i++) begin
         tick_cycle();
         check("resume_tick", i, tick,
               (i == 9 || i == 14 || i == 19) ? 4'b0100 : 4'b0000);
      end

      // P=1 on ch3: tick every cycle.
      en_write(4'b1000);
      cfg_write(2'd3, 1'b0, 32'd1);
      check("p1_tick", 0, tick, 4'b0000);
      for (int i = 1; i <= 5; i++) begin
         tick_cycle();
         check("p1_tick", i, tick, 4'b1000);
      end

      // P=0 on ch3: write lands on a terminal-count cycle, then silent forever.
      cfg_write(2'd3, 1'b0, 32'd0);
      check("p0_tick", 0, tick, 4'b0000);
      check("p0_busy", 0, busy, 4'b0000);
      for (int i = 1; i <= 4; i++) begin
         tick_cycle();
         check("p0_tick", i, tick, 4'b0000);
      end
      sync_pulse();
      check("p0_sync_busy", 0, busy, 4'b0000);
      for (int i = 1; i <= 2; i++) begin
         tick_cycle();
         check("p0_sync_tick", i, tick, 4'b0000);
      end

      // Reset on the edge that would have ticked.
      cfg_write(2'd3, 1'b0, 32'd3);
      tick_cycle();
      tick_cycle();
      reset = 1'b1;
      tick_cycle();
      check("midreset_tick", 0, tick, 4'b0000);
      check("midreset_busy", 0, busy, 4'b0000);
      check("midreset_cfg_rdy", 0, cfg_rdy, 1'b0);
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick_cycle();
         check("after_reset_tick", i, tick, 4'b0000);
         check("after_reset_busy", i, busy, 4'b0000);
      end
      // Periods were cleared, so enabling starts nothing.
      en_write(4'b1000);
      check("reset_cleared_period", 0, busy, 4'b0000);

      // nbits=8 instance: P=255 spacing on ch0, plus an ignored write to chan 3.
      en8_msg = 3'b111;
      en8_val = 1'b1;
      tick_cycle();
      en8_val  = 1'b0;
      cfg8_msg = {2'd0, 1'b0, 8'd255};
      cfg8_val = 1'b1;
      tick_cycle();
      cfg8_val = 1'b0;
      check("p255_busy", 0, busy8, 3'b001);
      for (int i = 1; i <= 520; i++) begin
         if (i == 10) begin
            cfg8_msg = {2'd3, 1'b0, 8'd1};
            cfg8_val = 1'b1;
         end else begin
            cfg8_val = 1'b0;
         end
         tick_cycle();
         check("p255_tick", i, tick8, (i == 255 || i == 510) ? 3'b001 : 3'b000);
         if (i == 10) begin
            check("chan_oob_busy", i, busy8, 3'b001);
         end
      end
      cfg8_val = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
